// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, fills IF/ID.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] Addr,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] IfId_Instr,
  output logic [31:0] IfId_PC,
  output logic [31:0] IfId_PC4,
  output logic        IfId_Valid,
  output logic        IfId_Fault,
  output logic [31:0] PerfFetchCnt,
  output logic [31:0] PerfStallCnt
);

  // Highest word-aligned address that still lies inside instruction memory.
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  assign Addr        = pc;
  assign pc_plus4    = pc + 32'd4;
  // Range check uses the full 32-bit PC so high addresses never alias into memory.
  assign fetch_fault = (pc[1:0] != 2'b00) || (pc > LAST_PC);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      IfId_Instr <= NOP_INSTR;
      IfId_PC    <= 32'd0;
      IfId_PC4   <= 32'd0;
      IfId_Valid <= 1'b0;
      IfId_Fault <= 1'b0;
    end else if (Redirect) begin
      // The word fetched at the old PC is on the wrong path: replace it with a bubble.
      pc         <= RedirectTarget;
      IfId_Instr <= NOP_INSTR;
      IfId_PC    <= pc;
      IfId_PC4   <= pc_plus4;
      IfId_Valid <= 1'b0;
      IfId_Fault <= 1'b0;
    end else if (!Stall) begin
      pc         <= pc_plus4;
      IfId_Instr <= fetch_fault ? NOP_INSTR : Instruction;
      IfId_PC    <= pc;
      IfId_PC4   <= pc_plus4;
      IfId_Valid <= 1'b1;
      IfId_Fault <= fetch_fault;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (!Redirect && !Stall) fetch_cnt <= fetch_cnt + 32'd1;
      if (!Redirect && Stall)  stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign PerfFetchCnt = fetch_cnt;
  assign PerfStallCnt = stall_cnt;
`else
  assign PerfFetchCnt = 32'd0;
  assign PerfStallCnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a behavioural pipeline model compared
// every cycle, plus hand-computed literal checks for the directed scenarios.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] instruction;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        ifid_fault;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0033;
  endfunction

  assign instruction = mem_word(addr);

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .Addr          (addr),
    .Instruction   (instruction),
    .Stall         (stall),
    .Redirect      (redirect),
    .RedirectTarget(redirect_target),
    .IfId_Instr    (ifid_instr),
    .IfId_PC       (ifid_pc),
    .IfId_PC4      (ifid_pc4),
    .IfId_Valid    (ifid_valid),
    .IfId_Fault    (ifid_fault),
    .PerfFetchCnt  (perf_fetch_cnt),
    .PerfStallCnt  (perf_stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must hold after each edge.
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid, m_fault, m_known = 1'b0;
  int unsigned m_fetches, m_stalls;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'd0; m_instr = NOP; m_ipc = 32'd0; m_ipc4 = 32'd0;
      m_valid = 1'b0; m_fault = 1'b0; m_fetches = 0; m_stalls = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (redirect) begin
        m_instr = NOP; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        m_valid = 1'b0; m_fault = 1'b0;
        m_pc = redirect_target;
      end else if (stall) begin
        m_stalls++;
      end else begin
        m_fault = (m_pc % 4 != 0) || (m_pc > 32'd1020);
        m_instr = m_fault ? NOP : mem_word(m_pc);
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        m_fetches++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("addr",       addr,       m_pc);
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_pc",    ifid_pc,    m_ipc);
      check("ifid_pc4",   ifid_pc4,   m_ipc4);
      check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      check("ifid_fault", {31'd0, ifid_fault}, {31'd0, m_fault});
`ifdef IF_PERF_CNT_EN
      check("perf_fetch", perf_fetch_cnt, m_fetches);
      check("perf_stall", perf_stall_cnt, m_stalls);
`else
      check("perf_fetch", perf_fetch_cnt, 32'd0);
      check("perf_stall", perf_stall_cnt, 32'd0);
`endif
    end
  end

  // Apply inputs for one edge, then let outputs settle just after it.
  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] tgt);
    rst = r; stall = s; redirect = rd; redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'd0;

    // Reset held for two edges.
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    check("rst_addr",  addr, 32'd0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'h13);

    run(1);
    check("f0_pc",    ifid_pc, 32'd0);
    check("f0_instr", ifid_instr, mem_word(32'd0));
    check("f0_valid", {31'd0, ifid_valid}, 32'd1);
    run(1);
    check("f1_pc", ifid_pc, 32'd4);
    check("f1_instr", ifid_instr, mem_word(32'd4));

    // Two stall cycles at PC=8.
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check("stall_addr",  addr, 32'd8);
    check("stall_pc",    ifid_pc, 32'd4);
    check("stall_instr", ifid_instr, mem_word(32'd4));
    run(1);
    check("unstall_pc", ifid_pc, 32'd8);

    // Redirect at PC=12.
    step(1'b0, 1'b0, 1'b1, 32'h40);
    check("redir_valid", {31'd0, ifid_valid}, 32'd0);
    check("redir_addr",  addr, 32'h40);
    check("redir_bpc",   ifid_pc, 32'd12);
    run(1);
    check("redir_pc",    ifid_pc, 32'h40);
    check("redir_valid1", {31'd0, ifid_valid}, 32'd1);

    // Redirect and stall together: redirect wins.
    step(1'b0, 1'b1, 1'b1, 32'h80);
    check("rs_addr",  addr, 32'h80);
    check("rs_valid", {31'd0, ifid_valid}, 32'd0);
    run(1);
    check("rs_pc", ifid_pc, 32'h80);

    // Misaligned fetch.
    step(1'b0, 1'b0, 1'b1, 32'h3FE);
    run(1);
    check("mis_fault", {31'd0, ifid_fault}, 32'd1);
    check("mis_instr", ifid_instr, 32'h13);
    check("mis_pc",    ifid_pc, 32'h3FE);
    check("mis_valid", {31'd0, ifid_valid}, 32'd1);

    // Upper edge of the legal range.
    step(1'b0, 1'b0, 1'b1, 32'h3F8);
    run(2);
    check("last_pc",    ifid_pc, 32'h3FC);
    check("last_fault", {31'd0, ifid_fault}, 32'd0);
    run(1);
    check("oor_pc",    ifid_pc, 32'h400);
    check("oor_fault", {31'd0, ifid_fault}, 32'd1);

    // PC+4 wraps at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(1);
    check("wrap_pc4",   ifid_pc4, 32'd0);
    check("wrap_addr",  addr, 32'd0);
    check("wrap_fault", {31'd0, ifid_fault}, 32'd1);

    // Reset mid-operation discards everything, even with stall asserted.
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check("mrst_addr",  addr, 32'd0);
    check("mrst_valid", {31'd0, ifid_valid}, 32'd0);
    check("mrst_instr", ifid_instr, 32'h13);

    // Ten edges, three of them stalled.
    run(2);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    run(2);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    run(3);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch_lit", perf_fetch_cnt, 32'd7);
    check("perf_stall_lit", perf_stall_cnt, 32'd3);
`else
    check("perf_fetch_lit", perf_fetch_cnt, 32'd0);
    check("perf_stall_lit", perf_stall_cnt, 32'd0);
`endif
    check("perf_addr", addr, 32'd28);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
